// File: rtl/pwm_pkg.sv
// Shared widths and the shadow-write bundle for the PWM edge preconditioner.
package pwm_pkg;

    localparam int PWM_WIDTH     = 13;
    localparam int PWM_TRANS_NUM = 249;

    typedef struct packed {
        logic [7:0]           idx;
        logic [PWM_WIDTH-1:0] left;
        logic [PWM_WIDTH-1:0] right;
        logic                 over;
    } pwm_entry_t;

endpackage

// File: rtl/pwm_precond_calc.sv
// Accept stage and edge-time arithmetic: centre/duty/period in, rise/fall/wrap out.
module pwm_precond_calc
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int TRANS_NUM = PWM_TRANS_NUM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_idx,
    input  logic [WIDTH-1:0] cycle,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] phase,
    output logic             out_valid,
    output logic [7:0]       out_idx,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             over
);

    localparam logic [7:0] LAST_IDX = 8'(TRANS_NUM - 1);

    logic             accept;
    logic             v1_q, v1_d;
    logic [7:0]       idx1_q, idx1_d;
    logic [WIDTH-1:0] cyc1_q, cyc1_d;
    logic [WIDTH-1:0] duty1_q, duty1_d;
    logic [WIDTH-1:0] ph1_q, ph1_d;
    logic             v2_q, v2_d;
    logic [7:0]       idx2_q, idx2_d;
    logic [WIDTH-1:0] left2_q, left2_d;
    logic [WIDTH-1:0] right2_q, right2_d;
    logic             over2_q, over2_d;

    logic [WIDTH:0]   cyc_x, ph_x, hlo_x, hhi_x;
    logic [WIDTH:0]   lsub, lwrap_sum, rsum, rdiff;
    logic             lwrap, rwrap;
    logic [1:0]       unused_msbs;

    assign accept = in_valid && (in_idx <= LAST_IDX);

    always_comb begin
        v1_d    = accept;
        idx1_d  = idx1_q;
        cyc1_d  = cyc1_q;
        duty1_d = duty1_q;
        ph1_d   = ph1_q;
        if (accept) begin
            idx1_d  = in_idx;
            cyc1_d  = cycle;
            duty1_d = duty;
            ph1_d   = phase;
        end
    end

    // lsub's top bit is the borrow of phase - h_lo, i.e. the left wrap
    always_comb begin
        cyc_x     = {1'b0, cyc1_q};
        ph_x      = {1'b0, ph1_q};
        hlo_x     = {2'b00, duty1_q[WIDTH-1:1]};
        hhi_x     = {1'b0, duty1_q} - hlo_x;
        lsub      = ph_x - hlo_x;
        lwrap_sum = lsub + cyc_x;
        rsum      = ph_x + hhi_x;
        rdiff     = rsum - cyc_x;
        lwrap     = lsub[WIDTH];
        rwrap     = (rsum >= cyc_x);

        v2_d     = v1_q;
        idx2_d   = idx1_q;
        left2_d  = lwrap ? lwrap_sum[WIDTH-1:0] : lsub[WIDTH-1:0];
        right2_d = rwrap ? rdiff[WIDTH-1:0] : rsum[WIDTH-1:0];
        over2_d  = lwrap | rwrap;
        if (duty1_q >= cyc1_q) begin
            left2_d  = '0;
            right2_d = cyc1_q;
            over2_d  = 1'b0;
        end else if (duty1_q == '0) begin
            left2_d  = ph1_q;
            right2_d = ph1_q;
            over2_d  = 1'b0;
        end
    end

    assign unused_msbs = {lwrap_sum[WIDTH], rdiff[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            idx1_q   <= '0;
            cyc1_q   <= '0;
            duty1_q  <= '0;
            ph1_q    <= '0;
            v2_q     <= 1'b0;
            idx2_q   <= '0;
            left2_q  <= '0;
            right2_q <= '0;
            over2_q  <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            idx1_q   <= idx1_d;
            cyc1_q   <= cyc1_d;
            duty1_q  <= duty1_d;
            ph1_q    <= ph1_d;
            v2_q     <= v2_d;
            idx2_q   <= idx2_d;
            left2_q  <= left2_d;
            right2_q <= right2_d;
            over2_q  <= over2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_idx   = idx2_q;
    assign left      = left2_q;
    assign right     = right2_q;
    assign over      = over2_q;

endmodule

// File: rtl/pwm_preconditioner.sv
// Double-buffered PWM edge table: entries land in shadow banks, and the
// last transducer index commits the whole frame to the live outputs.
module pwm_preconditioner
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int TRANS_NUM = PWM_TRANS_NUM
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    input  logic [7:0]                 IN_IDX,
    input  logic [WIDTH-1:0]           CYCLE,
    input  logic [WIDTH-1:0]           DUTY,
    input  logic [WIDTH-1:0]           PHASE,
    output logic [WIDTH*TRANS_NUM-1:0] LEFT,
    output logic [WIDTH*TRANS_NUM-1:0] RIGHT,
    output logic [TRANS_NUM-1:0]       OVER,
    output logic                       UPDATE
);

    localparam int         BANK     = WIDTH * TRANS_NUM;
    localparam logic [7:0] LAST_IDX = 8'(TRANS_NUM - 1);

    logic             calc_valid;
    logic [7:0]       calc_idx;
    logic [WIDTH-1:0] calc_left, calc_right;
    logic             calc_over;
    pwm_entry_t       ent;

    logic [BANK-1:0]      left_s_q, left_s_d;
    logic [BANK-1:0]      right_s_q, right_s_d;
    logic [TRANS_NUM-1:0] over_s_q, over_s_d;
    logic [BANK-1:0]      left_q, left_d;
    logic [BANK-1:0]      right_q, right_d;
    logic [TRANS_NUM-1:0] over_q, over_d;
    logic                 commit_q, commit_d;
    logic                 update_q, update_d;

    pwm_precond_calc #(
        .WIDTH     (WIDTH),
        .TRANS_NUM (TRANS_NUM)
    ) u_calc (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (IN_VALID),
        .in_idx    (IN_IDX),
        .cycle     (CYCLE),
        .duty      (DUTY),
        .phase     (PHASE),
        .out_valid (calc_valid),
        .out_idx   (calc_idx),
        .left      (calc_left),
        .right     (calc_right),
        .over      (calc_over)
    );

    assign ent = '{idx: calc_idx, left: calc_left, right: calc_right, over: calc_over};

    // Commit reads the pre-edge shadow, so a same-edge write joins the next frame
    always_comb begin
        left_s_d  = left_s_q;
        right_s_d = right_s_q;
        over_s_d  = over_s_q;
        commit_d  = 1'b0;
        if (calc_valid) begin
            left_s_d[int'(ent.idx)*WIDTH +: WIDTH]  = ent.left;
            right_s_d[int'(ent.idx)*WIDTH +: WIDTH] = ent.right;
            over_s_d[ent.idx]                       = ent.over;
            commit_d                                = (ent.idx == LAST_IDX);
        end
        left_d   = left_q;
        right_d  = right_q;
        over_d   = over_q;
        update_d = commit_q;
        if (commit_q) begin
            left_d  = left_s_q;
            right_d = right_s_q;
            over_d  = over_s_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            left_s_q  <= '0;
            right_s_q <= '0;
            over_s_q  <= '0;
            left_q    <= '0;
            right_q   <= '0;
            over_q    <= '0;
            commit_q  <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            left_s_q  <= left_s_d;
            right_s_q <= right_s_d;
            over_s_q  <= over_s_d;
            left_q    <= left_d;
            right_q   <= right_d;
            over_q    <= over_d;
            commit_q  <= commit_d;
            update_q  <= update_d;
        end
    end

    assign LEFT   = left_q;
    assign RIGHT  = right_q;
    assign OVER   = over_q;
    assign UPDATE = update_q;

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Randomised and directed bench for pwm_preconditioner against a frame-level model.
module tb_pwm_preconditioner;

    localparam int W  = 13;
    localparam int TN = 249;

    typedef struct {
        int at;
        int idx;
        int l;
        int r;
        int o;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_idx;
    logic [W-1:0]      cycle, duty, phase;
    logic [W*TN-1:0]   left_o, right_o;
    logic [TN-1:0]     over_o;
    logic              upd_o;

    int  m_ls[TN], m_rs[TN], m_os[TN];
    int  m_l[TN], m_r[TN], m_o[TN];
    wr_t wq[$];
    int  cq[$];
    int  edge_n;
    bit  exp_upd;
    bit  release_next;
    int  n_err;
    int  n_chk;

    pwm_preconditioner dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .IN_VALID (in_valid),
        .IN_IDX   (in_idx),
        .CYCLE    (cycle),
        .DUTY     (duty),
        .PHASE    (phase),
        .LEFT     (left_o),
        .RIGHT    (right_o),
        .OVER     (over_o),
        .UPDATE   (upd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge times from the pulse-centre definition, in plain integer arithmetic
    function automatic void calc_ref(input int c, input int d, input int p,
                                     output int l, output int r, output int o);
        int hl;
        int hh;
        hl = d / 2;
        hh = d - hl;
        if (d >= c) begin
            l = 0; r = c; o = 0;
        end else if (d == 0) begin
            l = p; r = p; o = 0;
        end else begin
            l = (((p - hl) % c) + c) % c;
            r = (p + hh) % c;
            o = ((p < hl) || (p + hh >= c)) ? 1 : 0;
        end
    endfunction

    function automatic logic [W*TN-1:0] pack_w(input int a[TN]);
        logic [W*TN-1:0] v;
        v = '0;
        for (int i = 0; i < TN; i++) v[i*W +: W] = W'(a[i]);
        return v;
    endfunction

    function automatic logic [TN-1:0] pack_o(input int a[TN]);
        logic [TN-1:0] v;
        v = '0;
        for (int i = 0; i < TN; i++) v[i] = a[i][0];
        return v;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < TN; i++)
            if (left_o[i*W +: W] !== W'(m_l[i]) || right_o[i*W +: W] !== W'(m_r[i])
                || over_o[i] !== m_o[i][0]) return i;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < TN; i++) begin
            m_ls[i] = 0; m_rs[i] = 0; m_os[i] = 0;
            m_l[i] = 0;  m_r[i] = 0;  m_o[i] = 0;
        end
        wq.delete();
        cq.delete();
        exp_upd = 1'b0;
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge
    task automatic step(input bit v, input int idx, input int c, input int d, input int p);
        wr_t w;
        int  l, r, o;
        @(negedge clk);
        if (release_next) begin
            rst_n = 1'b1;
            release_next = 1'b0;
        end
        in_valid = v;
        in_idx   = 8'(idx);
        cycle    = W'(c);
        duty     = W'(d);
        phase    = W'(p);
        @(posedge clk);
        if (rst_n) begin
            edge_n++;
            exp_upd = 1'b0;
            if (cq.size() > 0 && cq[0] == edge_n) begin
                void'(cq.pop_front());
                m_l = m_ls; m_r = m_rs; m_o = m_os;
                exp_upd = 1'b1;
            end
            if (wq.size() > 0 && wq[0].at == edge_n) begin
                w = wq.pop_front();
                m_ls[w.idx] = w.l; m_rs[w.idx] = w.r; m_os[w.idx] = w.o;
                if (w.idx == TN - 1) cq.push_back(edge_n + 1);
            end
            if (v && idx < TN) begin
                calc_ref(c, d, p, l, r, o);
                w.at = edge_n + 2; w.idx = idx; w.l = l; w.r = r; w.o = o;
                wq.push_back(w);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_idx = '0; cycle = '0; duty = '0; phase = '0;
        model_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 248, 4096, 100, 10);
        n_chk++;
        if (upd_o !== 1'b0) begin
            n_err++; $display("FAIL reset_update got %0b want 0", upd_o);
        end
        n_chk++;
        if (left_o !== '0) begin
            n_err++; $display("FAIL reset_left idx=%0d got %0d want 0", first_diff(), left_o[first_diff()*W +: W]);
        end
        n_chk++;
        if (right_o !== '0) begin
            n_err++; $display("FAIL reset_right idx=%0d got %0d want 0", first_diff(), right_o[first_diff()*W +: W]);
        end
        n_chk++;
        if (over_o !== '0) begin
            n_err++; $display("FAIL reset_over got nonzero want 0");
        end
        release_next = 1'b1;
    endtask

    task automatic test_directed();
        int tab[5][4];
        int k;
        tab = '{'{0, 1548, 2549, 0}, '{1, 3996, 300, 1}, '{2, 3800, 104, 1},
                '{3, 0, 4096, 0}, '{4, 7, 7, 0}};
        for (int s = 0; s < 10; s++) begin
            case (s)
                0: step(1'b1, 0, 4096, 1001, 2048);
                1: step(1'b1, 1, 4096, 400, 100);
                2: step(1'b1, 2, 4096, 400, 4000);
                3: step(1'b1, 3, 4096, 4096, 50);
                4: step(1'b1, 4, 4096, 0, 7);
                5: step(1'b1, 248, 4096, 10, 20);
                default: step(1'b0, int'($urandom_range(0, 255)), 9, 9, 9);
            endcase
            n_chk++;
            if (upd_o !== exp_upd) begin
                n_err++; $display("FAIL directed_update step=%0d got %0b want %0b", s, upd_o, exp_upd);
            end
        end
        for (int i = 0; i < 5; i++) begin
            k = tab[i][0];
            n_chk++;
            if (left_o[k*W +: W] !== W'(tab[i][1]) || right_o[k*W +: W] !== W'(tab[i][2])
                || over_o[k] !== tab[i][3][0]) begin
                n_err++;
                $display("FAIL directed_entry idx=%0d got %0d/%0d/%0b want %0d/%0d/%0d", k,
                         left_o[k*W +: W], right_o[k*W +: W], over_o[k], tab[i][1], tab[i][2], tab[i][3]);
            end
        end
    endtask

    task automatic test_random();
        int r, idx, c, d, p, k;
        bit v;
        for (int s = 0; s < 400; s++) begin
            v = ($urandom_range(0, 99) < 85);
            r = int'($urandom_range(0, 99));
            if (r < 10)      idx = TN - 1;
            else if (r < 15) idx = int'($urandom_range(TN, 255));
            else             idx = int'($urandom_range(0, TN - 2));
            c = int'($urandom_range(1, 8191));
            d = int'($urandom_range(0, c));
            p = int'($urandom_range(0, c - 1));
            step(v, idx, c, d, p);
            n_chk++;
            if (upd_o !== exp_upd) begin
                n_err++; $display("FAIL random_update step=%0d got %0b want %0b", s, upd_o, exp_upd);
            end
            n_chk++;
            if ({left_o, right_o, over_o} !== {pack_w(m_l), pack_w(m_r), pack_o(m_o)}) begin
                n_err++; k = first_diff();
                $display("FAIL random_outputs step=%0d idx=%0d got %0d/%0d/%0b want %0d/%0d/%0d", s, k,
                         left_o[k*W +: W], right_o[k*W +: W], over_o[k], m_l[k], m_r[k], m_o[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int last248, n_upd, k, c, d, p, i;
        last248 = 0;
        n_upd = 0;
        for (int s = 0; s < 2 * TN + 6; s++) begin
            i = s % TN;
            c = int'($urandom_range(2, 8191));
            d = int'($urandom_range(0, c));
            p = int'($urandom_range(0, c - 1));
            if (s >= 2 * TN)  step(1'b0, 0, c, d, p);
            else if (s == 0)  step(1'b1, 0, 100, 4, 10);
            else if (s == TN) step(1'b1, 0, 100, 4, 50);
            else              step(1'b1, i, c, d, p);
            if (s < 2 * TN && i == TN - 1) last248 = edge_n;
            n_chk++;
            if (upd_o !== exp_upd) begin
                n_err++; $display("FAIL b2b_update step=%0d got %0b want %0b", s, upd_o, exp_upd);
            end
            if (upd_o === 1'b1) begin
                n_upd++;
                n_chk++;
                if (edge_n - last248 != 3) begin
                    n_err++; $display("FAIL b2b_latency got %0d want 3", edge_n - last248);
                end
                n_chk++;
                if (left_o[W-1:0] !== W'(n_upd == 1 ? 8 : 48)) begin
                    n_err++; $display("FAIL b2b_idx0 commit=%0d got %0d want %0d", n_upd, left_o[W-1:0], n_upd == 1 ? 8 : 48);
                end
            end
            n_chk++;
            if ({left_o, right_o, over_o} !== {pack_w(m_l), pack_w(m_r), pack_o(m_o)}) begin
                n_err++; k = first_diff();
                $display("FAIL b2b_outputs step=%0d idx=%0d got %0d/%0d/%0b want %0d/%0d/%0d", s, k,
                         left_o[k*W +: W], right_o[k*W +: W], over_o[k], m_l[k], m_r[k], m_o[k]);
            end
        end
        n_chk++;
        if (n_upd != 2) begin
            n_err++; $display("FAIL b2b_pulses got %0d want 2", n_upd);
        end
    endtask

    task automatic test_reset_mid();
        int n_upd, k;
        for (int i = 0; i <= 100; i++) step(1'b1, i, 1000, 300, 500);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        n_chk++;
        if ({left_o, right_o, over_o, upd_o} !== '0) begin
            n_err++; $display("FAIL midreset_clear got nonzero outputs want 0");
        end
        step(1'b1, 101, 1000, 300, 500);
        step(1'b1, 248, 1000, 300, 500);
        release_next = 1'b1;
        n_upd = 0;
        // 249 and 255 lie beyond the table and must vanish without a commit
        for (int s = 0; s < 12; s++) begin
            case (s)
                0: step(1'b1, 248, 4096, 400, 4000);
                1: step(1'b1, 249, 4096, 400, 4000);
                6: step(1'b1, 255, 4096, 400, 4000);
                default: step(1'b0, 248, 1, 1, 1);
            endcase
            if (upd_o === 1'b1) n_upd++;
            n_chk++;
            if (upd_o !== exp_upd) begin
                n_err++; $display("FAIL midreset_update step=%0d got %0b want %0b", s, upd_o, exp_upd);
            end
            n_chk++;
            if ({left_o, right_o, over_o} !== {pack_w(m_l), pack_w(m_r), pack_o(m_o)}) begin
                n_err++; k = first_diff();
                $display("FAIL midreset_outputs step=%0d idx=%0d got %0d/%0d/%0b want %0d/%0d/%0d", s, k,
                         left_o[k*W +: W], right_o[k*W +: W], over_o[k], m_l[k], m_r[k], m_o[k]);
            end
        end
        n_chk++;
        if (n_upd != 1) begin
            n_err++; $display("FAIL midreset_pulses got %0d want 1", n_upd);
        end
        n_chk++;
        if (left_o[248*W +: W] !== W'(3800) || left_o[W-1:0] !== W'(0)) begin
            n_err++; $display("FAIL midreset_entries got %0d/%0d want 3800/0", left_o[248*W +: W], left_o[W-1:0]);
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        edge_n = 0;
        release_next = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
